// File: rtl/ex_branch_stage_if.sv
// rtl/ex_branch_stage_if.sv - EX-side inputs and EX/MEM pipeline register outputs
// slave: the stage consumes the EX side and drives the MEM side; master: the opposite view.
interface ex_branch_stage_if;
  logic        ex_valid;
  logic [15:0] alu_out;
  logic [3:0]  alu_cond;
  logic        set_cc;
  logic        is_branch;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [15:0] store_data;
  logic [2:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;

  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic [15:0] mem_store_data;
  logic [2:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;

  modport slave (
    input  ex_valid, alu_out, alu_cond, set_cc, is_branch, br_cond, br_target,
           store_data, rd, reg_write, mem_read, mem_write,
    output mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write
  );

  modport master (
    output ex_valid, alu_out, alu_cond, set_cc, is_branch, br_cond, br_target,
           store_data, rd, reg_write, mem_read, mem_write,
    input  mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write
  );
endinterface

// File: rtl/ex_branch_stage.sv
// rtl/ex_branch_stage.sv - EX/MEM register, S/Z/C/V condition codes and branch resolution with wrong-path squash
// Optional taken-branch counter built only when BRANCH_COUNT_EN is defined.
module ex_branch_stage #(
  parameter int SHADOW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  ex_branch_stage_if.slave      ex,
  output logic [3:0]            cc,
  output logic                  branch_taken,
  output logic [15:0]           branch_pc,
  output logic [15:0]           taken_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_SHADOW = 1'b1} state_e;

  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  cc_q, cc_d;
  logic        mem_valid_q, mem_valid_d;
  logic [15:0] mem_alu_q, mem_alu_d;
  logic [15:0] mem_store_q, mem_store_d;
  logic [2:0]  mem_rd_q, mem_rd_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_mr_q, mem_mr_d;
  logic        mem_mw_q, mem_mw_d;
  logic        branch_taken_q, branch_taken_d;
  logic [15:0] branch_pc_q, branch_pc_d;

  // flags layout {S,Z,C,V}; codes 5..7 are never taken
  function automatic logic cond_true(input logic [2:0] code, input logic [3:0] f);
    case (code)
      3'd0:    return 1'b1;
      3'd1:    return f[2];
      3'd2:    return f[3] ^ f[0];
      3'd3:    return f[2] | (f[3] ^ f[0]);
      3'd4:    return !f[2];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cc_d           = cc_q;
    mem_valid_d    = mem_valid_q;
    mem_alu_d      = mem_alu_q;
    mem_store_d    = mem_store_q;
    mem_rd_d       = mem_rd_q;
    mem_rw_d       = mem_rw_q;
    mem_mr_d       = mem_mr_q;
    mem_mw_d       = mem_mw_q;
    branch_taken_d = 1'b0;
    branch_pc_d    = branch_pc_q;

    if (flush) begin
      mem_valid_d = 1'b0;
      state_d     = ST_RUN;
      cnt_d       = 3'd0;
    end else if (!stall) begin
      mem_valid_d = 1'b0;
      if (ex.ex_valid) begin
        if (state_q == ST_SHADOW) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_RUN;
        end else begin
          mem_valid_d = 1'b1;
          mem_alu_d   = ex.alu_out;
          mem_store_d = ex.store_data;
          mem_rd_d    = ex.rd;
          mem_rw_d    = ex.reg_write;
          mem_mr_d    = ex.mem_read;
          mem_mw_d    = ex.mem_write;
          if (ex.set_cc) cc_d = ex.alu_cond;
          // branch sees the flags from before this instruction's own update
          if (ex.is_branch && cond_true(ex.br_cond, cc_q)) begin
            branch_taken_d = 1'b1;
            branch_pc_d    = ex.br_target;
            cnt_d          = SHADOW_CNT;
            state_d        = ST_SHADOW;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= 3'd0;
      cc_q           <= 4'd0;
      mem_valid_q    <= 1'b0;
      mem_alu_q      <= 16'd0;
      mem_store_q    <= 16'd0;
      mem_rd_q       <= 3'd0;
      mem_rw_q       <= 1'b0;
      mem_mr_q       <= 1'b0;
      mem_mw_q       <= 1'b0;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cc_q           <= cc_d;
      mem_valid_q    <= mem_valid_d;
      mem_alu_q      <= mem_alu_d;
      mem_store_q    <= mem_store_d;
      mem_rd_q       <= mem_rd_d;
      mem_rw_q       <= mem_rw_d;
      mem_mr_q       <= mem_mr_d;
      mem_mw_q       <= mem_mw_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
    end
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] taken_count_q, taken_count_d;

  always_comb begin
    taken_count_d = taken_count_q;
    if (branch_taken_q && (taken_count_q != 16'hFFFF)) taken_count_d = taken_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) taken_count_q <= 16'd0;
    else     taken_count_q <= taken_count_d;
  end

  assign taken_count = taken_count_q;
`else
  assign taken_count = 16'h0000;
`endif

  // control bits are gated so a dead slot can never write
  assign ex.mem_valid      = mem_valid_q;
  assign ex.mem_alu_out    = mem_alu_q;
  assign ex.mem_store_data = mem_store_q;
  assign ex.mem_rd         = mem_rd_q;
  assign ex.mem_reg_write  = mem_valid_q & mem_rw_q;
  assign ex.mem_mem_read   = mem_valid_q & mem_mr_q;
  assign ex.mem_mem_write  = mem_valid_q & mem_mw_q;
  assign cc                = cc_q;
  assign branch_taken      = branch_taken_q;
  assign branch_pc         = branch_pc_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// tb/tb_ex_branch_stage.sv - scoreboard bench for ex_branch_stage (directed prelude, then random traffic)
module tb_ex_branch_stage;
  localparam int SH = 2;
`ifdef BRANCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [3:0]  cc;
  logic        branch_taken;
  logic [15:0] branch_pc, taken_count;

  ex_branch_stage_if u_if ();

  ex_branch_stage #(.SHADOW(SH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex(u_if),
    .cc(cc), .branch_taken(branch_taken), .branch_pc(branch_pc), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mv;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        rw, mr, mw;
    logic [3:0]  cc;
    logic        bt;
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   shadow_left;
  int   checks = 0;
  int   errors = 0;

  logic        i_rst, i_stall, i_flush, i_v, i_scc, i_br, i_rw, i_mr, i_mw;
  logic [15:0] i_alu, i_tgt, i_sd;
  logic [3:0]  i_cond;
  logic [2:0]  i_bc, i_rd;

  function automatic bit taken_rule(input logic [2:0] code, input logic [3:0] f);
    bit s = f[3], z = f[2], v = f[0];
    if (code == 0) return 1;
    if (code == 1) return z;
    if (code == 2) return s != v;
    if (code == 3) return z || (s != v);
    if (code == 4) return !z;
    return 0;
  endfunction

  // reference: what the outputs must be after the coming edge
  task automatic model();
    bit was_taken = m.bt;
    if (i_rst) begin
      m = '0;
      shadow_left = 0;
      return;
    end
    if (CNT_EN && was_taken && m.cnt != 16'hFFFF) m.cnt = m.cnt + 1;
    m.bt = 0;
    if (i_flush) begin
      m.mv = 0;
      shadow_left = 0;
    end else if (!i_stall) begin
      m.mv = 0;
      if (i_v && shadow_left > 0) begin
        shadow_left = shadow_left - 1;
      end else if (i_v) begin
        m.mv = 1; m.alu = i_alu; m.sd = i_sd; m.rd = i_rd;
        m.rw = i_rw; m.mr = i_mr; m.mw = i_mw;
        if (i_br && taken_rule(i_bc, m.cc)) begin
          m.bt = 1;
          m.pc = i_tgt;
          shadow_left = SH;
        end
        if (i_scc) m.cc = i_cond;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = i_rst; stall = i_stall; flush = i_flush;
    u_if.ex_valid = i_v; u_if.alu_out = i_alu; u_if.alu_cond = i_cond;
    u_if.set_cc = i_scc; u_if.is_branch = i_br; u_if.br_cond = i_bc;
    u_if.br_target = i_tgt; u_if.store_data = i_sd; u_if.rd = i_rd;
    u_if.reg_write = i_rw; u_if.mem_read = i_mr; u_if.mem_write = i_mw;
    model();
    q.push_back(m);
  endtask

  task automatic idle();
    i_rst = 0; i_stall = 0; i_flush = 0; i_v = 0; i_scc = 0; i_br = 0;
    i_rw = 0; i_mr = 0; i_mw = 0; i_alu = 0; i_tgt = 0; i_sd = 0;
    i_cond = 0; i_bc = 0; i_rd = 0;
  endtask

  task automatic issue(input logic [15:0] alu, input logic [3:0] cnd, input logic scc,
                       input logic br, input logic [2:0] bc, input logic [15:0] tgt);
    idle();
    i_v = 1; i_alu = alu; i_cond = cnd; i_scc = scc; i_br = br; i_bc = bc; i_tgt = tgt;
    i_sd = alu ^ 16'h5A5A; i_rd = alu[2:0]; i_rw = 1; i_mw = alu[0];
    step();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_valid", 16'(u_if.mem_valid), 16'(e.mv));
        chk("mem_reg_write", 16'(u_if.mem_reg_write), 16'(e.mv & e.rw));
        chk("mem_mem_read", 16'(u_if.mem_mem_read), 16'(e.mv & e.mr));
        chk("mem_mem_write", 16'(u_if.mem_mem_write), 16'(e.mv & e.mw));
        if (e.mv) begin
          chk("mem_alu_out", u_if.mem_alu_out, e.alu);
          chk("mem_store_data", u_if.mem_store_data, e.sd);
          chk("mem_rd", 16'(u_if.mem_rd), 16'(e.rd));
        end
        chk("cc", 16'(cc), 16'(e.cc));
        chk("branch_taken", 16'(branch_taken), 16'(e.bt));
        if (e.bt) chk("branch_pc", branch_pc, e.pc);
        chk("taken_count", taken_count, e.cnt);
      end
    end
  end

  initial begin
    idle();
    m = '0;
    shadow_left = 0;
    rst = 1; stall = 0; flush = 0;
    u_if.ex_valid = 0; u_if.alu_out = 0; u_if.alu_cond = 0; u_if.set_cc = 0;
    u_if.is_branch = 0; u_if.br_cond = 0; u_if.br_target = 0; u_if.store_data = 0;
    u_if.rd = 0; u_if.reg_write = 0; u_if.mem_read = 0; u_if.mem_write = 0;

    idle(); i_rst = 1; step(); step();
    issue(16'h1234, 4'b0000, 1, 0, 0, 0);
    issue(16'h0000, 4'b0100, 1, 0, 0, 0);
    issue(16'h0002, 4'b0000, 0, 1, 3'd1, 16'h0040);
    issue(16'h0011, 4'b1111, 1, 0, 0, 0);
    idle(); step();
    issue(16'h0022, 4'b1111, 1, 1, 3'd0, 16'h0099);
    issue(16'h0033, 4'b1000, 1, 0, 0, 0);
    issue(16'h0044, 4'b0000, 0, 1, 3'd2, 16'h0100);
    issue(16'h0055, 4'b0000, 0, 0, 0, 0);
    issue(16'h0066, 4'b0000, 0, 0, 0, 0);
    issue(16'h0077, 4'b1001, 1, 0, 0, 0);
    issue(16'h0088, 4'b0000, 0, 1, 3'd2, 16'h0200);
    issue(16'h0099, 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      idle(); i_v = 1; i_br = 1; i_bc = 3'd0; i_tgt = 16'h0300; i_alu = 16'h00AA;
      i_stall = (k < 3);
      step();
    end
    issue(16'h00BB, 4'b0000, 0, 0, 0, 0);
    idle(); i_flush = 1; step();
    issue(16'h00CC, 4'b0000, 0, 0, 0, 0);
    issue(16'h00DD, 4'b0000, 0, 1, 3'd5, 16'h0400);
    issue(16'h00EE, 4'b0000, 0, 0, 0, 0);
    issue(16'h00FF, 4'b0000, 0, 1, 3'd4, 16'h0500);
    issue(16'h0100, 4'b0000, 0, 0, 0, 0);
    issue(16'h0101, 4'b0000, 0, 0, 0, 0);
    idle(); step(); step();

    for (int n = 0; n < 3000; n++) begin
      idle();
      i_rst   = ($urandom_range(0, 199) == 0);
      i_stall = ($urandom_range(0, 6) == 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_v     = ($urandom_range(0, 3) != 0);
      i_alu   = 16'($urandom);
      i_sd    = 16'($urandom);
      i_tgt   = 16'($urandom);
      i_cond  = 4'($urandom);
      i_bc    = 3'($urandom);
      i_rd    = 3'($urandom);
      i_scc   = 1'($urandom);
      i_br    = ($urandom_range(0, 2) == 0);
      i_rw    = 1'($urandom);
      i_mr    = 1'($urandom);
      i_mw    = 1'($urandom);
      step();
    end
    idle(); step();

    @(posedge clk);
    #3;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_branch_stage.md
# ex_branch_stage

Execute-side EX/MEM stage of the 16-bit pipeline, directly downstream of the ALU. It latches the ALU result and its 4-bit condition vector into the EX/MEM pipeline register. It maintains the architected condition-code register (S, Z, C, V) and resolves conditional branches against it. A taken branch produces a one-cycle redirect and squashes the configured number of younger wrong-path instructions.

## Interface
Parameters:
- SHADOW, 2: number of younger valid instructions squashed after a taken branch (1..7).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all state; input instruction not consumed
- flush  in  1  kill the instruction in this stage and any pending shadow
- ex_valid  in  1  instruction present at EX
- alu_out  in  16  ALU result
- alu_cond  in  4  ALU condition vector: [3]=S, [2]=Z, [1]=C, [0]=V
- set_cc  in  1  instruction writes the condition-code register
- is_branch  in  1  instruction is a branch
- br_cond  in  3  0=B (always), 1=BE, 2=BLT, 3=BLE, 4=BNE, 5..7=never
- br_target  in  16  branch target address
- store_data  in  16  register operand for stores
- rd  in  3  destination register
- reg_write, mem_read, mem_write  in  1 each  control bits
- mem_valid  out  1  EX/MEM register holds a live instruction
- mem_alu_out, mem_store_data  out  16 each  latched copies
- mem_rd  out  3
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  latched control bits; forced to 0 when mem_valid=0
- cc  out  4  architected flags {S,Z,C,V}
- branch_taken  out  1  one-cycle redirect pulse
- branch_pc  out  16  target valid while branch_taken=1
- taken_count  out  16  taken-branch counter (see Configuration)

## Operation
- Acceptance: an instruction is accepted on an edge with ex_valid=1, stall=0, flush=0, rst=0.
- Priority: rst > flush > stall > normal.
- Reset: every output is 0, cc=0000, and the FSM is in RUN.
- FSM states:
  - RUN: an accepted instruction is latched. If set_cc=1, cc <= alu_cond. If is_branch=1 and the condition is true against the current cc, then branch_taken=1, branch_pc=br_target, the counter loads SHADOW, and the FSM enters SHADOW.
  - SHADOW: each accepted instruction is squashed: mem_valid=0, no cc update, no branch evaluation, counter decrements. At counter 1, a squashed acceptance returns the FSM to RUN. Cycles with ex_valid=0 do not decrement the counter.
- Branch conditions, evaluated on cc before any update by the same instruction:
  - BE = Z
  - BLT = S^V
  - BLE = Z|(S^V)
  - BNE = !Z
  - B = 1
  - codes 5..7 are never taken.
- Same instruction sets cc and branches: the branch uses the old cc, and cc still updates.
- Branch instruction itself: always passes to MEM (mem_valid=1) with its control bits, so a link write can use reg_write.
- flush: mem_valid <= 0, FSM <= RUN, branch_taken <= 0. cc is unchanged.
- stall: all registers hold. branch_taken is forced low during stall so the redirect is never repeated.

## Timing
- Latency: 1 cycle from acceptance edge to mem_* and cc outputs.
- branch_taken: high for exactly one cycle, the cycle after the branch's acceptance edge.
- Flags: an instruction immediately following a flag-setting instruction sees the updated cc, because the update is registered at the earlier instruction's acceptance edge.
- Back-to-back: one instruction per cycle, with no bubbles when stall=0.
- Branch arriving during SHADOW: squashed and not evaluated.
- rst mid-SHADOW: the FSM returns to RUN and the counter clears.

## Configuration
- BRANCH_COUNT_EN defined:
  - taken_count increments on each branch_taken pulse and saturates at 16'hFFFF.
  - cleared by rst only.
- BRANCH_COUNT_EN undefined: taken_count is tied to 16'h0000 and no counter logic is built.

## Test plan
- Reset, then ADD with alu_out=16'h1234, alu_cond=4'b0000, set_cc=1 -> next cycle mem_valid=1, mem_alu_out=16'h1234, cc=0000.
- SUB setting cc=4'b0100 (Z), then BE with br_target=16'h0040 -> branch_taken=1 for one cycle, branch_pc=16'h0040. The next 2 valid instructions give mem_valid=0 and leave cc unchanged; the 3rd is latched.
- cc=4'b1000 (S=1, V=0), then BLT -> taken. With cc=4'b1001, BLT -> not taken, branch_taken stays 0, and the FSM stays in RUN.
- stall=1 for 3 cycles while a taken branch is held at EX -> no outputs change and there is a single branch_taken pulse after stall drops.
- flush asserted during SHADOW -> mem_valid=0 next cycle, and the next valid instruction is latched normally.
- With BRANCH_COUNT_EN: 3 taken branches plus 1 not-taken -> taken_count=3. Without it, taken_count=0.
